// File: rtl/drlp_dma_pkg.sv
// Shared types for the DRLP DMA responder: write-path FSM states and
// the arbiter side encoding used by the memory-port round-robin.
package drlp_dma_pkg;

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_PEND = 2'd1,
    WS_ACK  = 2'd2
  } wstate_e;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_side_e;

endpackage

// File: rtl/drlp_dma_rq_fifo.sv
// Synchronous read-request FIFO; accepts a push on a full FIFO when a pop
// happens in the same cycle.
module drlp_dma_rq_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/drlp_dma_responder.sv
// Memory-side responder for the DRLP DMA master: queues reads, buffers one
// write, and serialises both onto a registered valid/ready memory port.
module drlp_dma_responder
  import drlp_dma_pkg::*;
#(
  parameter int DMA_ADDR_WIDTH = 32,
  parameter int DMA_DATA_WIDTH = 32,
  parameter int RQ_DEPTH       = 8,
  parameter int MAX_OUTST      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_dma_rd_en,
  input  logic [DMA_ADDR_WIDTH-1:0] i_dma_rd_addr,
  input  logic                      i_dma_wr_en,
  input  logic [DMA_ADDR_WIDTH-1:0] i_dma_wr_addr,
  input  logic [DMA_DATA_WIDTH-1:0] i_dma_wr_data,
  output logic [DMA_DATA_WIDTH-1:0] o_dma_rd_data,
  output logic                      o_dma_rd_ready,
  output logic                      o_hand_shaked,
  output logic                      o_mem_req_v,
  output logic                      o_mem_req_we,
  output logic [DMA_ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DMA_DATA_WIDTH-1:0] o_mem_req_data,
  input  logic                      i_mem_req_ready,
  input  logic                      i_mem_rsp_v,
  input  logic [DMA_DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic                      o_err_ovf
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  wstate_e                   wstate;
  wstate_e                   wstate_nxt;
  arb_side_e                 last_side;
  logic [DMA_ADDR_WIDTH-1:0] wbuf_addr;
  logic [DMA_DATA_WIDTH-1:0] wbuf_data;
  logic [OW-1:0]             outst;
  logic [OW:0]               rd_inflight;
  logic [DMA_ADDR_WIDTH-1:0] rq_head;
  logic                      rq_full;
  logic                      rq_empty;
  logic                      rq_pop;
  logic                      mem_acc;
  logic                      slot_free;
  logic                      rd_cand;
  logic                      wr_cand;
  logic                      grant_rd;
  logic                      grant_wr;

  drlp_dma_rq_fifo #(
    .DATA_W (DMA_ADDR_WIDTH),
    .DEPTH  (RQ_DEPTH)
  ) u_rq_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (i_dma_rd_en),
    .push_data (i_dma_rd_addr),
    .pop       (rq_pop),
    .pop_data  (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  // A read sitting in the request register counts against the cap, so the
  // memory never sees more than MAX_OUTST unanswered reads.
  assign mem_acc     = o_mem_req_v && i_mem_req_ready;
  assign slot_free   = !o_mem_req_v || mem_acc;
  assign rd_inflight = {1'b0, outst} + (OW+1)'(o_mem_req_v && !o_mem_req_we);
  assign rd_cand     = !rq_empty && (rd_inflight < (OW+1)'(MAX_OUTST));
  assign wr_cand     = (wstate == WS_PEND) && !(o_mem_req_v && o_mem_req_we);
  assign grant_rd    = slot_free && rd_cand && (!wr_cand || last_side == ARB_WR);
  assign grant_wr    = slot_free && wr_cand && (!rd_cand || last_side == ARB_RD);
  assign rq_pop      = grant_rd;

  always_comb begin
    wstate_nxt    = wstate;
    o_hand_shaked = 1'b0;
    unique case (wstate)
      WS_IDLE: if (i_dma_wr_en) wstate_nxt = WS_PEND;
      WS_PEND: if (mem_acc && o_mem_req_we) wstate_nxt = WS_ACK;
      WS_ACK: begin
        o_hand_shaked = 1'b1;
        wstate_nxt    = WS_IDLE;
      end
      default: wstate_nxt = WS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstate    <= WS_IDLE;
      last_side <= ARB_RD;
      outst     <= '0;
      o_err_ovf <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      if (grant_rd) last_side <= ARB_RD;
      if (grant_wr) last_side <= ARB_WR;
      if (i_dma_rd_en && rq_full && !rq_pop) o_err_ovf <= 1'b1;
      // A response arriving with nothing outstanding is not counted.
      unique case ({mem_acc && !o_mem_req_we, i_mem_rsp_v && (outst != '0)})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wstate == WS_IDLE && i_dma_wr_en) begin
      wbuf_addr <= i_dma_wr_addr;
      wbuf_data <= i_dma_wr_data;
    end
  end

  // Request register: loads only when empty or being accepted, so a
  // presented request stays frozen until the memory takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req_v    <= 1'b0;
      o_mem_req_we   <= 1'b0;
      o_mem_req_addr <= '0;
      o_mem_req_data <= '0;
    end else if (grant_rd) begin
      o_mem_req_v    <= 1'b1;
      o_mem_req_we   <= 1'b0;
      o_mem_req_addr <= rq_head;
    end else if (grant_wr) begin
      o_mem_req_v    <= 1'b1;
      o_mem_req_we   <= 1'b1;
      o_mem_req_addr <= wbuf_addr;
      o_mem_req_data <= wbuf_data;
    end else if (mem_acc) begin
      o_mem_req_v    <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dma_rd_ready <= 1'b0;
      o_dma_rd_data  <= '0;
    end else begin
      o_dma_rd_ready <= i_mem_rsp_v;
      if (i_mem_rsp_v) o_dma_rd_data <= i_mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_drlp_dma_responder.sv
// Bench for drlp_dma_responder: transaction-level model of the capture,
// ordering, outstanding and response rules checked every cycle.
module tb_drlp_dma_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int MAXO  = 2;
  localparam int M_IDLE = 0, M_PEND = 1, M_ACK = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] dma_rd_data;
  logic          dma_rd_ready;
  logic          hand_shaked;
  logic          req_v;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          mem_ready;
  logic          rsp_v;
  logic [DW-1:0] rsp_data;
  logic          err_ovf;

  always #5 clk = ~clk;

  drlp_dma_responder #(
    .DMA_ADDR_WIDTH (AW),
    .DMA_DATA_WIDTH (DW),
    .RQ_DEPTH       (DEPTH),
    .MAX_OUTST      (MAXO)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_dma_rd_en     (rd_en),
    .i_dma_rd_addr   (rd_addr),
    .i_dma_wr_en     (wr_en),
    .i_dma_wr_addr   (wr_addr),
    .i_dma_wr_data   (wr_data),
    .o_dma_rd_data   (dma_rd_data),
    .o_dma_rd_ready  (dma_rd_ready),
    .o_hand_shaked   (hand_shaked),
    .o_mem_req_v     (req_v),
    .o_mem_req_we    (req_we),
    .o_mem_req_addr  (req_addr),
    .o_mem_req_data  (req_data),
    .i_mem_req_ready (mem_ready),
    .i_mem_rsp_v     (rsp_v),
    .i_mem_rsp_data  (rsp_data),
    .o_err_ovf       (err_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } mrsp_t;

  logic [AW-1:0] exp_rd[$];
  mrsp_t         memq[$];
  logic [DW-1:0] rdy_log[$];
  int            grant_log[$];
  int            occ, outst, last_due, ws, w_wait;
  bit            exp_ovf, w_presented;
  logic [AW-1:0] m_waddr, wacc_addr;
  logic [DW-1:0] m_wdata, wacc_data, exp_held;
  logic          p_v, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  int            n_rd_acc, n_wr_acc, n_rdy, n_hs;
  int            ready_mode, lat_min, lat_max;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_rd.delete();
    memq.delete();
    occ = 0; outst = 0; last_due = 0; ws = M_IDLE; w_wait = 0;
    exp_ovf = 0; w_presented = 0; exp_held = '0;
    p_v = 0; p_we = 0; p_addr = '0; p_data = '0;
  endtask

  task automatic step();
    bit acc, newp, pop;
    int inflight, d;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      chk("reset_ovf", err_ovf, 0);
      chk("reset_outs", |{dma_rd_data, dma_rd_ready, hand_shaked, req_v, req_we, req_addr, req_data}, 0);
      model_reset();
      rsp_v = 0;
      mem_ready = 0;
      return;
    end
    acc = p_v && mem_ready;
    if (acc && !p_we) begin
      if (exp_rd.size() == 0) chk("spurious_read", p_addr, '1);
      else begin
        a = exp_rd.pop_front();
        chk("rd_addr_order", p_addr, a);
      end
      outst++;
      n_rd_acc++;
      grant_log.push_back(0);
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      memq.push_back(mrsp_t'{data: mem_word(p_addr), due: d});
      last_due = d;
    end
    if (acc && p_we) begin
      chk("wr_accept_pending", ws == M_PEND, 1);
      chk("wr_addr", p_addr, m_waddr);
      chk("wr_data", p_data, m_wdata);
      n_wr_acc++;
      grant_log.push_back(1);
      wacc_addr = p_addr;
      wacc_data = p_data;
    end
    chk("hand_shaked", hand_shaked, acc && p_we);
    if (hand_shaked) n_hs++;
    if (rsp_v) begin
      chk("rd_ready", dma_rd_ready, 1);
      chk("rd_data", dma_rd_data, rsp_data);
      exp_held = rsp_data;
      if (outst > 0) outst--;
      n_rdy++;
      rdy_log.push_back(dma_rd_data);
    end else begin
      chk("rd_ready_idle", dma_rd_ready, 0);
      chk("rd_data_hold", dma_rd_data, exp_held);
    end
    if (p_v && !mem_ready) begin
      chk("req_hold_v", req_v, 1);
      chk("req_hold_we", req_we, p_we);
      chk("req_hold_addr", req_addr, p_addr);
      if (p_we) chk("req_hold_data", req_data, p_data);
    end
    newp = req_v && (!p_v || acc);
    pop  = newp && !req_we;
    if (newp && req_we) begin
      chk("wr_present_legal", ws == M_PEND && !w_presented, 1);
      chk("wr_present_addr", req_addr, m_waddr);
      chk("wr_present_data", req_data, m_wdata);
      w_presented = 1;
    end
    if (pop) chk("pop_nonempty", occ > 0, 1);
    inflight = outst + ((req_v && !req_we) ? 1 : 0);
    chk("outst_cap", inflight <= MAXO, 1);
    if (rd_en) begin
      if (occ < DEPTH || pop) begin
        exp_rd.push_back(rd_addr);
        occ++;
      end else exp_ovf = 1;
    end
    if (pop) occ--;
    chk("err_ovf", err_ovf, exp_ovf);
    case (ws)
      M_ACK:  ws = M_IDLE;
      M_IDLE: if (wr_en) begin
        ws = M_PEND; m_waddr = wr_addr; m_wdata = wr_data;
        w_presented = 0; w_wait = 0;
      end
      default: if (acc && p_we) ws = M_ACK;
    endcase
    if (ws == M_PEND) begin
      w_wait++;
      if (w_wait == 41) chk("write_wait_bound", w_wait, 40);
    end
    p_v = req_v; p_we = req_we; p_addr = req_addr; p_data = req_data;
    mem_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_v = 1;
      rsp_data = memq[0].data;
      void'(memq.pop_front());
    end else begin
      rsp_v = 0;
      rsp_data = $urandom;
    end
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    rd_en = 0;
    ready_mode = 1;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (hand_shaked) wr_en = 0;
      done = exp_rd.size() == 0 && memq.size() == 0 && outst == 0 && occ == 0 &&
             ws == M_IDLE && !p_v && !wr_en && !rsp_v;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic core_wr_drive(input int pct);
    if (hand_shaked) wr_en = 0;
    else if (!wr_en && $urandom_range(99, 0) < pct) begin
      wr_en = 1;
      wr_addr = $urandom & ~32'h3;
      wr_data = $urandom;
    end
  endtask

  initial begin
    int base, runs, run, nw, nr, n;
    logic [DW-1:0] lit[4];
    lit = '{32'hA5A5_0100, 32'hA5A5_0104, 32'hA5A5_0108, 32'hA5A5_010C};
    rst_n = 0; rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    mem_ready = 0; rsp_v = 0; rsp_data = '0;
    ready_mode = 1; lat_min = 0; lat_max = 0;
    n_rd_acc = 0; n_wr_acc = 0; n_rdy = 0; n_hs = 0;
    model_reset();
    step(); step();
    rst_n = 1;
    step();

    // single read: t -> request visible at t+2
    rd_en = 1; rd_addr = 32'h100;
    step();
    chk("lat_rd_t1", req_v, 0);
    rd_en = 0;
    step();
    chk("lat_rd_t2_v", req_v, 1);
    chk("lat_rd_t2_addr", req_addr, 32'h100);
    drain(60);

    // four-word burst, memory latency 3
    lat_min = 3; lat_max = 3;
    rdy_log.delete();
    base = n_rd_acc;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 32'h100 + 32'(4 * i);
      step();
    end
    drain(80);
    chk("burst_reads", n_rd_acc - base, 4);
    chk("burst_pulses", rdy_log.size(), 4);
    for (int i = 0; i < 4 && i < rdy_log.size(); i++) chk("burst_data", rdy_log[i], lit[i]);

    // write with memory stalled for 5 cycles
    ready_mode = 0;
    step();
    base = n_wr_acc; n = n_hs;
    wr_en = 1; wr_addr = 32'h200; wr_data = 32'hDEAD_BEEF;
    step();
    chk("lat_wr_t1", req_v, 0);
    step();
    chk("lat_wr_t2_v", req_v, 1);
    chk("lat_wr_t2_we", req_we, 1);
    for (int i = 0; i < 4; i++) step();
    ready_mode = 1;
    for (int i = 0; i < 20 && wr_en; i++) begin
      step();
      if (hand_shaked) wr_en = 0;
    end
    drain(40);
    chk("wr_count", n_wr_acc - base, 1);
    chk("hs_count", n_hs - n, 1);
    chk("wr_lit_addr", wacc_addr, 32'h200);
    chk("wr_lit_data", wacc_data, 32'hDEAD_BEEF);

    // overflow: one read moves into the request register, eight fill the FIFO
    lat_min = 0; lat_max = 2;
    ready_mode = 0;
    step();
    base = n_rd_acc;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1; rd_addr = 32'h300 + 32'(4 * i);
      step();
      if (i == 8) chk("ovf_not_yet", err_ovf, 0);
    end
    chk("ovf_set", err_ovf, 1);
    rd_en = 0;
    for (int i = 0; i < 3; i++) step();
    chk("ovf_sticky", err_ovf, 1);
    drain(100);
    chk("ovf_served", n_rd_acc - base, 9);
    chk("ovf_sticky_after", err_ovf, 1);

    // asynchronous reset in the middle of a burst
    ready_mode = 1;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1; rd_addr = 32'h400 + 32'(4 * i);
      step();
    end
    rst_n = 0; rd_en = 0;
    #1;
    chk("async_rst_ovf", err_ovf, 0);
    chk("async_rst_outs", |{dma_rd_data, dma_rd_ready, hand_shaked, req_v, req_we, req_addr, req_data}, 0);
    step(); step();
    rst_n = 1;
    step();

    // outstanding cap with a slow memory
    lat_min = 10; lat_max = 10;
    base = n_rd_acc; n = n_rdy;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 32'h500 + 32'(4 * i);
      step();
    end
    rd_en = 0;
    for (int i = 0; i < 40 && n_rdy == n; i++) step();
    chk("cap_before_rsp", n_rd_acc - base, 2);
    drain(100);
    chk("cap_total", n_rd_acc - base, 4);

    // contention: reads always queued, writes re-raised after each ack
    lat_min = 0; lat_max = 0;
    n = grant_log.size();
    for (int i = 0; i < 200 && grant_log.size() < n + 16; i++) begin
      rd_en = 1; rd_addr = $urandom & ~32'h3;
      core_wr_drive(100);
      step();
    end
    rd_en = 0;
    nw = 0; nr = 0; run = 0; runs = 0;
    for (int i = n; i < n + 16 && i < grant_log.size(); i++) begin
      if (grant_log[i] == 1) begin nw++; run = 0; end
      else begin nr++; run++; if (run > runs) runs = run; end
    end
    chk("cont_writes_min", nw >= 2, 1);
    chk("cont_reads_min", nr >= 2, 1);
    chk("cont_read_run", runs <= 3, 1);
    drain(200);

    // randomized traffic with random backpressure and latency
    rst_n = 0;
    step();
    rst_n = 1;
    lat_min = 0; lat_max = 6;
    ready_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      rd_en = ($urandom_range(2, 0) == 0);
      rd_addr = $urandom & ~32'h3;
      core_wr_drive(25);
      step();
    end
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
